tone_voice: RTL and testbench

- Downstream consumer of the song sequencer's 16-bit note word (songout).
- The incoming word is a half-period in clk50 cycles; 0 means rest.
- Block outputs:
  - a square wave for the speaker pin;
  - an envelope-shaped signed 16-bit sample stream, strobed at the audio sample rate, for the DAC path.
- It registers the sequencer's combinational output and removes clicks on note changes with an attack/release envelope.

---
 rtl/tone_pkg.sv | 25 ++
 rtl/tone_osc.sv | 46 ++++
 rtl/tone_voice.sv | 147 ++++++++++++++
 tb/tb_tone_voice.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// tone_pkg: shared widths, default constants, envelope state type and the
// sample sign helper for the tone_voice block.
package tone_pkg;

    localparam int AMP_W = 16;
    localparam int PER_W = 16;

    localparam int unsigned      DEF_SAMPLE_DIV = 1042;     // 50 MHz / 48 kHz
    localparam logic [AMP_W-1:0] DEF_AMP_MAX    = 16'h3FFF;
    localparam logic [AMP_W-1:0] DEF_ENV_STEP   = 16'h0100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } env_state_t;

    // Square-wave sample: +mag while phase is high, -mag while low.
    function automatic logic [AMP_W-1:0] signed_level(input logic             phase,
                                                      input logic [AMP_W-1:0] mag);
        return phase ? mag : -mag;
    endfunction

endpackage

// File: rtl/tone_osc.sv
// tone_osc: registers the sequencer note word, flags changes to it and
// generates the square-wave phase (half-period = period_q clk50 cycles).
module tone_osc
    import tone_pkg::*;
(
    input  logic             clk50,
    input  logic             reset,
    input  logic [PER_W-1:0] note_period,
    output logic             chg,
    output logic             period_zero,
    output logic             phase
);

    logic [PER_W-1:0] period_q;
    logic [PER_W-1:0] hp_cnt;
    logic             hp_wrap;

    // Change detect compares the raw (possibly glitchy) input to last cycle's copy.
    assign chg         = (note_period != period_q);
    assign period_zero = (period_q == '0);
    assign hp_wrap     = (hp_cnt == period_q - 1'b1);

    // Input register plus half-period counter; a new note restarts from phase 0.
    always_ff @(posedge clk50) begin
        if (reset) begin
            period_q <= '0;
            hp_cnt   <= '0;
            phase    <= 1'b0;
        end else begin
            period_q <= note_period;
            if (chg) begin
                hp_cnt <= '0;
                phase  <= 1'b0;
            end else if (period_zero) begin
                hp_cnt <= '0;
                phase  <= 1'b0;
            end else if (hp_wrap) begin
                hp_cnt <= '0;
                phase  <= ~phase;
            end else begin
                hp_cnt <= hp_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tone_voice.sv
// tone_voice: note word -> speaker square wave plus an envelope-shaped signed
// sample stream strobed every SAMPLE_DIV clk50 cycles.
// Optional feature macro: TONE_VOICE_ENV_EN (attack/release envelope FSM).
// Without it the level is a flat AMP_MAX while a note is held.
module tone_voice
    import tone_pkg::*;
#(
    parameter int unsigned      SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter logic [AMP_W-1:0] AMP_MAX    = DEF_AMP_MAX
`ifdef TONE_VOICE_ENV_EN
    ,
    parameter logic [AMP_W-1:0] ENV_STEP   = DEF_ENV_STEP
`endif
)(
    input  logic             clk50,
    input  logic             reset,
    input  logic [PER_W-1:0] note_period,
    output logic             spk,
    output logic [AMP_W-1:0] sample,
    output logic             sample_valid,
    output logic             note_active
);

    localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic             chg;
    logic             period_zero;
    logic             phase;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    tone_osc u_osc (
        .clk50       (clk50),
        .reset       (reset),
        .note_period (note_period),
        .chg         (chg),
        .period_zero (period_zero),
        .phase       (phase)
    );

    // phase is already cleared whenever period_q is 0; the gate keeps spk
    // silent on rests independent of the oscillator's internal sequencing.
    assign spk = phase & ~period_zero;

    assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

    // Free-running sample-rate divider; note changes do not realign it.
    always_ff @(posedge clk50) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

`ifdef TONE_VOICE_ENV_EN

    env_state_t       state;
    logic [AMP_W-1:0] env;
    logic [AMP_W:0]   env_up;
    logic             env_top;
    logic             env_bottom;

    // Attack sum carries a 17th bit so AMP_MAX near full scale cannot wrap.
    assign env_up     = {1'b0, env} + {1'b0, ENV_STEP};
    assign env_top    = (env_up >= {1'b0, AMP_MAX});
    assign env_bottom = (env <= ENV_STEP);

    // Envelope FSM with registered sample/strobe/activity outputs.
    // A note change wins over a coincident tick: state moves, env holds.
    always_ff @(posedge clk50) begin
        if (reset) begin
            state        <= IDLE;
            env          <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            note_active  <= 1'b0;
        end else begin
            sample_valid <= tick;
            note_active  <= (state != IDLE);
            if (tick) begin
                sample <= (state == IDLE) ? '0 : signed_level(phase, env);
            end
            if (chg) begin
                if (note_period != '0) begin
                    state <= ATTACK;
                end else if (state != IDLE) begin
                    state <= RELEASE;
                end
            end else if (tick) begin
                case (state)
                    ATTACK: begin
                        if (env_top) begin
                            env   <= AMP_MAX;
                            state <= SUSTAIN;
                        end else begin
                            env <= env_up[AMP_W-1:0];
                        end
                    end
                    SUSTAIN: begin
                        env <= env;
                    end
                    RELEASE: begin
                        if (env_bottom) begin
                            env   <= '0;
                            state <= IDLE;
                        end else begin
                            env <= env - ENV_STEP;
                        end
                    end
                    IDLE: begin
                        env <= '0;
                    end
                endcase
            end
        end
    end

`else

    logic [AMP_W-1:0] env_lvl;
    logic             unused_chg;

    // Flat level: the tick that samples a held note already sees full scale.
    assign env_lvl    = period_zero ? '0 : AMP_MAX;
    assign unused_chg = chg;

    // Registered sample, strobe and activity with no envelope shaping.
    always_ff @(posedge clk50) begin
        if (reset) begin
            sample       <= '0;
            sample_valid <= 1'b0;
            note_active  <= 1'b0;
        end else begin
            sample_valid <= tick;
            note_active  <= ~period_zero;
            if (tick) begin
                sample <= signed_level(phase, env_lvl);
            end
        end
    end

`endif

endmodule

// File: tb/tb_tone_voice.sv
// tb_tone_voice: scoreboard bench for tone_voice (SAMPLE_DIV=8, ENV_STEP=0x1000).
module tb_tone_voice;

    localparam int unsigned SDIV = 8;
    localparam int          AMP  = 32'h3FFF;
    localparam int          STEP = 32'h1000;

    logic        clk50 = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] note_period = 16'd100;
    logic        spk;
    logic [15:0] sample;
    logic        sample_valid;
    logic        note_active;

    int errors = 0;
    int checks = 0;

    always #5 clk50 = ~clk50;

    tone_voice #(
        .SAMPLE_DIV (SDIV),
        .AMP_MAX    (16'h3FFF)
`ifdef TONE_VOICE_ENV_EN
        ,
        .ENV_STEP   (16'h1000)
`endif
    ) dut (
        .clk50        (clk50),
        .reset        (reset),
        .note_period  (note_period),
        .spk          (spk),
        .sample       (sample),
        .sample_valid (sample_valid),
        .note_active  (note_active)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model, stepped on each rising edge from the driven inputs.
    logic [15:0] m_period = '0;
    int          m_n      = 0;
    int          m_div    = 0;
    int          m_env    = 0;
    int          m_state  = 0;   // 0 idle, 1 attack, 2 sustain, 3 release
    logic        m_phase  = 1'b0;
    logic        m_valid  = 1'b0;
    logic        m_active = 1'b0;
    logic [15:0] sb[$];

    always @(posedge clk50) begin : model
        logic ch, tk;
        int   mag, e;
        if (reset) begin
            m_period = '0; m_n = 0; m_div = 0; m_env = 0; m_state = 0;
            m_phase = 1'b0; m_valid = 1'b0; m_active = 1'b0;
            sb.delete();
        end else begin
            ch = (note_period != m_period);
            tk = (m_div == int'(SDIV) - 1);
            m_valid = tk;
`ifdef TONE_VOICE_ENV_EN
            m_active = (m_state != 0);
            if (tk) begin
                mag = (m_state == 0) ? 0 : m_env;
                sb.push_back(m_phase ? 16'(mag) : 16'(-mag));
            end
            if (ch) begin
                if (note_period != 0) m_state = 1;
                else if (m_state != 0) m_state = 3;
            end else if (tk) begin
                if (m_state == 1) begin
                    e = m_env + STEP;
                    if (e >= AMP) begin m_env = AMP; m_state = 2; end
                    else m_env = e;
                end else if (m_state == 3) begin
                    e = m_env - STEP;
                    if (e <= 0) begin m_env = 0; m_state = 0; end
                    else m_env = e;
                end else if (m_state == 0) begin
                    m_env = 0;
                end
            end
`else
            m_active = (m_period != 0);
            if (tk) begin
                mag = (m_period != 0) ? AMP : 0;
                sb.push_back(m_phase ? 16'(mag) : 16'(-mag));
            end
`endif
            if (ch) m_n = 0;
            else if (m_period != 0) m_n++;
            m_period = note_period;
            m_phase  = (m_period == 0) ? 1'b0 : (((m_n / int'(m_period)) % 2) == 1);
            m_div    = (m_div + 1) % int'(SDIV);
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk50) begin
        check("spk", 32'(spk), 32'(m_phase && (m_period != 0)));
        check("note_active", 32'(note_active), 32'(m_active));
        check("sample_valid", 32'(sample_valid), 32'(m_valid));
        if (sample_valid) begin
            check("sb_depth", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check("sample", 32'(sample), 32'(sb.pop_front()));
        end
    end

    task automatic wait_div(input int k);
        int n = 0;
        while (m_div != k && n < 4 * int'(SDIV)) begin
            @(negedge clk50);
            n++;
        end
        if (m_div != k) check("wait_div", 32'(m_div), 32'(k));
    endtask

    task automatic grab_mag(input string tag, input logic [15:0] exp);
        int          n = 0;
        logic [15:0] m;
        do begin
            @(negedge clk50);
            n++;
        end while (!sample_valid && n < 4 * int'(SDIV));
        if (!sample_valid) begin
            check({tag, "_timeout"}, 32'(sample_valid), 32'd1);
        end else begin
            m = sample[15] ? 16'(-sample) : sample;
            check(tag, 32'(m), 32'(exp));
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin : stim
        logic [15:0] pers[7];
        pers = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd5, 16'd9, 16'd200};

        // reset held with a note present, then one cycle after release
        repeat (3) begin
            @(negedge clk50);
            check("rst_spk", 32'(spk), 32'd0);
            check("rst_sample", 32'(sample), 32'd0);
            check("rst_valid", 32'(sample_valid), 32'd0);
            check("rst_active", 32'(note_active), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk50);
        check("post_rst_spk", 32'(spk), 32'd0);
        check("post_rst_sample", 32'(sample), 32'd0);
        check("post_rst_active", 32'(note_active), 32'd0);

        // oscillator: period 4 then period 1
        note_period = 16'd4;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk50);
            check("osc4", 32'(spk), 32'((i / 4) % 2));
        end
        repeat (64) @(negedge clk50);
        note_period = 16'd1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk50);
            check("osc1", 32'(spk), 32'(i % 2));
        end
        repeat (12) @(negedge clk50);
        note_period = 16'd0;
        repeat (60) @(negedge clk50);

`ifdef TONE_VOICE_ENV_EN
        // attack from idle
        wait_div(2);
        note_period = 16'd4;
        grab_mag("att0", 16'h0000);
        grab_mag("att1", 16'h1000);
        grab_mag("att2", 16'h2000);
        grab_mag("att3", 16'h3000);
        grab_mag("att4", 16'h3FFF);
        grab_mag("sus", 16'h3FFF);

        // release from sustain
        wait_div(2);
        note_period = 16'd0;
        @(negedge clk50);
        check("rel_spk", 32'(spk), 32'd0);
        grab_mag("rel0", 16'h3FFF);
        grab_mag("rel1", 16'h2FFF);
        grab_mag("rel2", 16'h1FFF);
        grab_mag("rel3", 16'h0FFF);
        grab_mag("rel_idle", 16'h0000);
        check("rel_active", 32'(note_active), 32'd0);

        // retrigger on a tick cycle while at env 0x2000
        wait_div(2);
        note_period = 16'd4;
        grab_mag("col_a0", 16'h0000);
        grab_mag("col_a1", 16'h1000);
        wait_div(7);
        note_period = 16'd6;
        @(negedge clk50);
        check("col_spk", 32'(spk), 32'd0);
        check("col_sample", 32'(sample[15] ? 16'(-sample) : sample), 32'h2000);
        grab_mag("col_hold", 16'h2000);
        grab_mag("col_next", 16'h3000);
        note_period = 16'd0;
        repeat (60) @(negedge clk50);
`else
        // flat level
        wait_div(2);
        note_period = 16'd5;
        grab_mag("flat_on", 16'h3FFF);
        grab_mag("flat_hold", 16'h3FFF);
        wait_div(2);
        note_period = 16'd0;
        grab_mag("flat_off", 16'h0000);
        check("flat_active", 32'(note_active), 32'd0);
`endif

        // random note sequence checked by the model
        for (int i = 0; i < 14; i++) begin
            note_period = pers[$urandom_range(0, 6)];
            repeat ($urandom_range(5, 60)) @(negedge clk50);
        end

        // reset in the middle of a note
        note_period = 16'd5;
        repeat (40) @(negedge clk50);
        reset = 1'b1;
        @(negedge clk50);
        check("midrst_spk", 32'(spk), 32'd0);
        check("midrst_sample", 32'(sample), 32'd0);
        check("midrst_active", 32'(note_active), 32'd0);
        reset = 1'b0;
        repeat (30) @(negedge clk50);
        note_period = 16'd0;
        repeat (60) @(negedge clk50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
